// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX constants and the TX framer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam int          ETH_PRE_LEN  = 7;
  localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;

  // Each state names the kind of byte the framer loads into its output register next.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_BODY,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } eth_tx_state_t;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide IEEE 802.3 CRC-32 step (reflected, data bits consumed LSB-first).
// Latency: purely combinational.
// Backpressure: none; caller decides when to register crc_out.
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_v;

  // Eight serial shift/XOR steps unrolled into one cycle.
  always_comb begin
    crc_v = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_v[0] ^ data[i]) begin
        crc_v = {1'b0, crc_v[31:1]} ^ ETH_CRC_POLY;
      end else begin
        crc_v = {1'b0, crc_v[31:1]};
      end
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, SFD, body, zero pad, FCS and inter-frame gap as one byte stream.
// Latency: first preamble byte one cycle after s_valid seen in IDLE; body bytes one cycle after acceptance.
// Backpressure: m_ready low freezes the output register and the FSM; s_ready follows the output register slot in BODY.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_BODY  = 60,
  parameter int IFG_SLOTS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_first,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [10:0] MIN_B    = 11'(MIN_BODY);
  localparam logic [2:0]  PRE_LAST = 3'(ETH_PRE_LEN - 1);
  // The IDLE cycle in front of the next preamble is itself the final gap slot,
  // so the IFG state only has to cover IFG_SLOTS-1 of them.
  localparam logic [15:0] IFG_LAST = (IFG_SLOTS > 1) ? 16'(IFG_SLOTS - 1) : 16'd0;

  eth_tx_state_t state_q, state_d;
  logic [2:0]    pre_cnt_q, pre_cnt_d;
  logic [10:0]   body_cnt_q, body_cnt_d;
  logic [2:0]    fcs_cnt_q, fcs_cnt_d;
  logic [15:0]   ifg_cnt_q, ifg_cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_first_q, m_first_d;
  logic          m_last_q, m_last_d;
  logic          frame_done_q, frame_done_d;

  logic          load_ok;
  logic          accept;
  logic [7:0]    crc_byte;
  logic [31:0]   crc_next;
  logic [10:0]   cnt_inc;
  logic [31:0]   fcs_word;
  logic [7:0]    fcs_byte;

  // Output register slot is free when empty or being drained this cycle.
  assign load_ok    = ~m_valid_q | m_ready;
  assign s_ready    = (state_q == ST_BODY) & load_ok;
  assign accept     = s_valid & s_ready;
  assign underrun   = (state_q == ST_BODY) & m_ready & ~s_valid;
  assign busy       = (state_q != ST_IDLE);
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_first    = m_first_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;

  assign crc_byte = (state_q == ST_PAD) ? 8'h00 : s_data;
  assign cnt_inc  = (body_cnt_q == 11'h7FF) ? body_cnt_q : body_cnt_q + 11'd1;
  assign fcs_word = ~crc_q;

  eth_crc32 u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  // FCS goes out least-significant byte first.
  always_comb begin
    unique case (fcs_cnt_q[1:0])
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end

  // Next-state and output-register loading; a drained slot with nothing to load goes empty.
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    body_cnt_d   = body_cnt_q;
    fcs_cnt_d    = fcs_cnt_q;
    ifg_cnt_d    = ifg_cnt_q;
    crc_d        = crc_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_first_d    = m_first_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;

    if (load_ok) begin
      m_valid_d = 1'b0;
      m_first_d = 1'b0;
      m_last_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          m_valid_d  = 1'b1;
          m_data_d   = ETH_PREAMBLE;
          m_first_d  = 1'b1;
          pre_cnt_d  = 3'd1;
          crc_d      = ETH_CRC_INIT;
          body_cnt_d = 11'd0;
          fcs_cnt_d  = 3'd0;
          state_d    = ST_PRE;
        end
      end
      ST_PRE: begin
        if (load_ok) begin
          m_valid_d = 1'b1;
          m_data_d  = ETH_PREAMBLE;
          pre_cnt_d = pre_cnt_q + 3'd1;
          if (pre_cnt_q == PRE_LAST) begin
            state_d = ST_SFD;
          end
        end
      end
      ST_SFD: begin
        if (load_ok) begin
          m_valid_d = 1'b1;
          m_data_d  = ETH_SFD;
          state_d   = ST_BODY;
        end
      end
      ST_BODY: begin
        if (accept) begin
          m_valid_d  = 1'b1;
          m_data_d   = s_data;
          crc_d      = crc_next;
          body_cnt_d = cnt_inc;
          if (s_last) begin
            state_d = (cnt_inc < MIN_B) ? ST_PAD : ST_FCS;
          end
        end
      end
      ST_PAD: begin
        if (load_ok) begin
          m_valid_d  = 1'b1;
          m_data_d   = 8'h00;
          crc_d      = crc_next;
          body_cnt_d = cnt_inc;
          if (cnt_inc >= MIN_B) begin
            state_d = ST_FCS;
          end
        end
      end
      ST_FCS: begin
        if (fcs_cnt_q == 3'd4) begin
          // All four FCS bytes loaded; leave once the last one is taken.
          if (m_ready) begin
            frame_done_d = 1'b1;
            ifg_cnt_d    = 16'd0;
            state_d      = ST_IFG;
          end
        end else if (load_ok) begin
          m_valid_d = 1'b1;
          m_data_d  = fcs_byte;
          m_last_d  = (fcs_cnt_q == 3'd3);
          fcs_cnt_d = fcs_cnt_q + 3'd1;
        end
      end
      ST_IFG: begin
        if (IFG_LAST == 16'd0) begin
          state_d = ST_IDLE;
        end else if (m_ready) begin
          if (ifg_cnt_q + 16'd1 >= IFG_LAST) begin
            state_d = ST_IDLE;
          end else begin
            ifg_cnt_d = ifg_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, CRC and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= 3'd0;
      body_cnt_q   <= 11'd0;
      fcs_cnt_q    <= 3'd0;
      ifg_cnt_q    <= 16'd0;
      crc_q        <= ETH_CRC_INIT;
      m_valid_q    <= 1'b0;
      m_data_q     <= 8'h00;
      m_first_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      body_cnt_q   <= body_cnt_d;
      fcs_cnt_q    <= fcs_cnt_d;
      ifg_cnt_q    <= ifg_cnt_d;
      crc_q        <= crc_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_first_q    <= m_first_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
